// File: rtl/camera_pkg.sv
// ---------------------------------------------------------------------------
// camera_pkg : shared states, mode encodings and pixel conversion for the
//              camera frame writer.
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package camera_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } cam_state_t;

  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_CONT   = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Keep the top four bits of each RGB565 channel.
  function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/camera_pixel_decimator.sv
// ---------------------------------------------------------------------------
// camera_pixel_decimator : x/y raster counters, decimation keep strobe and
//                          linear write address for one captured frame.
// Revision               : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module camera_pixel_decimator #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 1,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic              keep,
  output logic              y_over,
  output logic [ADDR_W-1:0] addr
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_MASK = XW'(DECIM - 1);
  localparam logic [YW-1:0] Y_MASK = YW'(DECIM - 1);
  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // y parks at V_ACTIVE once the frame is full, so extra lines never wrap.
  assign y_over = (y == Y_END);
  assign keep   = !y_over && ((x & X_MASK) == '0) && ((y & Y_MASK) == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance && !y_over) begin
      if (keep) begin
        addr <= addr + ADDR_W'(1);
      end
      if (x == X_LAST) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/camera_frame_writer.sv
// ---------------------------------------------------------------------------
// camera_frame_writer : captures decimated camera frames into a frame buffer,
//                       optional double buffering via
//                       CAMERA_FRAME_WRITER_DOUBLE_BUFFER_EN.
// Revision            : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module camera_frame_writer
  import camera_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 1,
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 19
) (
  input  logic              camera_clk,
  input  logic              reset,
  input  logic              camera_pixel_valid,
  input  logic [15:0]       camera_pixel,
  input  logic              camera_frame_done,
  input  logic [1:0]        mode,
  input  logic              capture_frame,
  output logic [ADDR_W:0]   memory_addr,
  output logic [DATA_W-1:0] memory_data,
  output logic              memory_we,
  output logic              busy,
  output logic [7:0]        frame_count,
  output logic              read_bank,
  output logic              frame_short,
  output logic              overflow
);

  localparam int FULL = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);

  cam_state_t state, state_next;

  logic              capture_prev;
  logic              capture_rise;
  logic              stop;
  logic              start_capture;
  logic              in_capture;
  logic              pixel_step;
  logic              close_frame;
  logic              keep;
  logic              y_over;
  logic              write_now;
  logic              overflow_hit;
  logic              frame_is_short;
  logic              write_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   wcount_next;
  logic [DATA_W-1:0] pixel_data;

  assign capture_rise   = capture_frame && !capture_prev;
  assign stop           = (mode == MODE_STOP) || (mode == MODE_RSVD);
  assign in_capture     = (state == ST_CAPTURE);
  assign start_capture  = (state == ST_ARMED) && camera_frame_done && !stop;
  assign pixel_step     = in_capture && camera_pixel_valid && !stop;
  assign close_frame    = in_capture && camera_frame_done && !stop;
  assign write_now      = pixel_step && keep;
  assign overflow_hit   = pixel_step && y_over;
  // A pixel coinciding with frame_done still counts towards completeness.
  assign wcount_next    = {1'b0, wr_addr} + (ADDR_W + 1)'(write_now);
  assign frame_is_short = (wcount_next < (ADDR_W + 1)'(FULL));
  assign busy           = (state == ST_ARMED) || (state == ST_CAPTURE);

  camera_pixel_decimator #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .DECIM    (DECIM),
    .ADDR_W   (ADDR_W)
  ) u_decim (
    .clk     (camera_clk),
    .reset   (reset),
    .clear   (start_capture),
    .advance (pixel_step),
    .keep    (keep),
    .y_over  (y_over),
    .addr    (wr_addr)
  );

  generate
    if (DATA_W == 12) begin : g_rgb444
      assign pixel_data = rgb565_to_rgb444(camera_pixel);
    end else begin : g_rgb565
      assign pixel_data = camera_pixel;
    end
  endgenerate

`ifdef CAMERA_FRAME_WRITER_DOUBLE_BUFFER_EN
  logic read_bank_q;
  always_ff @(posedge camera_clk) begin
    if (reset) begin
      write_bank  <= 1'b0;
      read_bank_q <= 1'b0;
    end else if (close_frame) begin
      read_bank_q <= write_bank;
      write_bank  <= ~write_bank;
    end
  end
  assign read_bank = read_bank_q;
`else
  assign write_bank = 1'b0;
  assign read_bank  = 1'b0;
`endif

  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          if ((mode == MODE_CONT) || ((mode == MODE_SINGLE) && capture_rise))
            state_next = ST_ARMED;
        ST_ARMED:
          if (camera_frame_done) state_next = ST_CAPTURE;
        ST_CAPTURE:
          if (camera_frame_done)
            state_next = (mode == MODE_CONT) ? ST_ARMED : ST_HOLD;
        ST_HOLD:
          if (!capture_frame) state_next = ST_IDLE;
        default:
          state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge camera_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      capture_prev <= 1'b0;
      memory_we    <= 1'b0;
      memory_addr  <= '0;
      memory_data  <= '0;
      frame_count  <= 8'd0;
      frame_short  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_next;
      capture_prev <= capture_frame;
      memory_we    <= write_now;
      if (write_now) begin
        memory_addr <= {write_bank, wr_addr};
        memory_data <= pixel_data;
      end
      if (start_capture) begin
        frame_short <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (overflow_hit) overflow <= 1'b1;
        if (close_frame && frame_is_short) frame_short <= 1'b1;
      end
      if (close_frame) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_camera_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_camera_frame_writer : directed table-driven bench for camera_frame_writer
//                          (4x2 RGB444 instance and 8x4 DECIM=2 RGB565 one).
// Revision               : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_camera_frame_writer;

`ifdef CAMERA_FRAME_WRITER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  typedef struct {
    logic [15:0] pix;
    logic [11:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, valid, fd, capture;
  logic [15:0] pixel;
  logic [1:0]  mode_a, mode_b;

  logic [4:0]  addr_a, addr_b;
  logic [11:0] data_a;
  logic [15:0] data_b;
  logic        we_a, we_b, busy_a, busy_b, rb_a, rb_b;
  logic        short_a, short_b, ovf_a, ovf_b;
  logic [7:0]  fc_a, fc_b;

  int checks = 0;
  int failures = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int bad_addr_a = 0;
  int exp_fc_a = 0;
  bit exp_bank_a = 1'b0;
  bit exp_rb_a = 1'b0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  camera_frame_writer #(
    .H_ACTIVE(4), .V_ACTIVE(2), .DECIM(1), .DATA_W(12), .ADDR_W(4)
  ) dut_a (
    .camera_clk(clk), .reset(reset), .camera_pixel_valid(valid),
    .camera_pixel(pixel), .camera_frame_done(fd), .mode(mode_a),
    .capture_frame(capture), .memory_addr(addr_a), .memory_data(data_a),
    .memory_we(we_a), .busy(busy_a), .frame_count(fc_a), .read_bank(rb_a),
    .frame_short(short_a), .overflow(ovf_a)
  );

  camera_frame_writer #(
    .H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .DATA_W(16), .ADDR_W(4)
  ) dut_b (
    .camera_clk(clk), .reset(reset), .camera_pixel_valid(valid),
    .camera_pixel(pixel), .camera_frame_done(fd), .mode(mode_b),
    .capture_frame(capture), .memory_addr(addr_b), .memory_data(data_b),
    .memory_we(we_b), .busy(busy_b), .frame_count(fc_b), .read_bank(rb_b),
    .frame_short(short_b), .overflow(ovf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of camera inputs, then sample just after the edge.
  task automatic step(input logic v, input logic [15:0] p, input logic f);
    @(negedge clk);
    valid = v;
    pixel = p;
    fd    = f;
    @(posedge clk);
    #1;
    if (we_a) wr_cnt_a++;
    if (we_b) wr_cnt_b++;
    if (we_a && (addr_a[3:0] > 4'd7)) bad_addr_a++;
  endtask

  task automatic close_a(input logic v, input logic [15:0] p);
    step(v, p, 1'b1);
    exp_fc_a++;
    exp_rb_a   = DB & exp_bank_a;
    exp_bank_a = exp_bank_a ^ DB;
    chk("frame_count_a", fc_a, exp_fc_a & 8'hFF);
    chk("read_bank_a", rb_a, exp_rb_a);
  endtask

  task automatic frame_a();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].pix, 1'b0);
      chk("frame_we_a", we_a, 1'b1);
      chk("frame_addr_a", addr_a, {exp_bank_a, 4'(i)});
      chk("frame_data_a", data_a, vecs[i].exp_data);
    end
    step(1'b0, 16'h0, 1'b0);
    chk("we_pulse_a", we_a, 1'b0);
  endtask

  initial begin
    int base;
    bit bank_save;
    vecs[0] = '{16'hF81F, 12'hF0F};
    vecs[1] = '{16'hFFFF, 12'hFFF};
    vecs[2] = '{16'h0000, 12'h000};
    vecs[3] = '{16'h07E0, 12'h0F0};
    vecs[4] = '{16'h001F, 12'h00F};
    vecs[5] = '{16'h8410, 12'h888};
    vecs[6] = '{16'h1234, 12'h14A};
    vecs[7] = '{16'hA5A5, 12'hAB2};

    reset = 1'b1; valid = 1'b0; fd = 1'b0; pixel = 16'h0;
    capture = 1'b0; mode_a = 2'b00; mode_b = 2'b00;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    reset = 1'b0;
    step(1'b0, 16'h0, 1'b0);
    chk("rst_we_a", we_a, 1'b0);
    chk("rst_addr_a", addr_a, 5'd0);
    chk("rst_data_a", data_a, 12'h0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_fc_a", fc_a, 8'd0);
    chk("rst_rb_a", rb_a, 1'b0);
    chk("rst_short_a", short_a, 1'b0);
    chk("rst_ovf_a", ovf_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);

    // Continuous mode, two full frames on the 4x2 instance.
    mode_a = 2'b01;
    step(1'b0, 16'h0, 1'b0);
    chk("s1_armed_busy", busy_a, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    frame_a();
    close_a(1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b1);
    frame_a();
    close_a(1'b0, 16'h0);
    chk("s1_short", short_a, 1'b0);
    chk("s1_ovf", ovf_a, 1'b0);
    mode_a = 2'b00;
    step(1'b0, 16'h0, 1'b0);
    chk("s1_stop_busy", busy_a, 1'b0);

    // Decimate-by-2 on the 8x4 RGB565 instance.
    mode_b = 2'b01;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    base = wr_cnt_b;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        logic [15:0] p;
        logic        kept;
        p    = {8'(y), 8'(x)};
        kept = ((x % 2) == 0) && ((y % 2) == 0);
        step(1'b1, p, 1'b0);
        chk("s2_we", we_b, kept);
        if (kept) begin
          chk("s2_addr", addr_b, (y / 2) * 4 + x / 2);
          chk("s2_data", data_b, p);
        end
      end
    end
    step(1'b0, 16'h0, 1'b1);
    chk("s2_writes", wr_cnt_b - base, 8);
    chk("s2_fc", fc_b, 8'd1);
    chk("s2_short", short_b, 1'b0);
    chk("s2_ovf", ovf_b, 1'b0);
    chk("s2_rb", rb_b, 1'b0);
    mode_b = 2'b00;
    step(1'b0, 16'h0, 1'b0);

    // Single-shot with capture_frame held across three frame_done pulses.
    mode_a = 2'b10;
    step(1'b0, 16'h0, 1'b0);
    chk("s4_no_edge_idle", busy_a, 1'b0);
    capture = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    chk("s4_armed", busy_a, 1'b1);
    base = wr_cnt_a;
    step(1'b0, 16'h0, 1'b1);
    frame_a();
    close_a(1'b0, 16'h0);
    chk("s4_hold_busy", busy_a, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h1111, 1'b1);
    chk("s4_hold_fc", fc_a, 8'd3);
    chk("s4_hold_busy2", busy_a, 1'b0);
    chk("s4_one_frame", wr_cnt_a - base, 8);
    capture = 1'b0;
    step(1'b0, 16'h0, 1'b0);
    capture = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    chk("s4_rearm_from_idle", busy_a, 1'b1);
    mode_a = 2'b00;
    capture = 1'b0;
    step(1'b0, 16'h0, 1'b0);
    chk("s4_stop", busy_a, 1'b0);

    // Short frame, then an over-long frame, then pixel coinciding with done.
    mode_a = 2'b01;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, vecs[i].pix, 1'b0);
    close_a(1'b0, 16'h0);
    chk("s5_short_set", short_a, 1'b1);
    chk("s5_short_ovf", ovf_a, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("s5_short_cleared", short_a, 1'b0);
    base = wr_cnt_a;
    bad_addr_a = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 16'(i), 1'b0);
      if (i == 8) chk("s5_ovf_we", we_a, 1'b0);
    end
    chk("s5_ovf_set", ovf_a, 1'b1);
    chk("s5_ovf_writes", wr_cnt_a - base, 8);
    chk("s5_ovf_addr", bad_addr_a, 0);
    close_a(1'b0, 16'h0);
    chk("s5_ovf_sticky", ovf_a, 1'b1);
    chk("s5_ovf_full", short_a, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("s5_ovf_cleared", ovf_a, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, vecs[i].pix, 1'b0);
    bank_save = exp_bank_a;
    close_a(1'b1, vecs[7].pix);
    chk("s5_coinc_we", we_a, 1'b1);
    chk("s5_coinc_addr", addr_a, {bank_save, 4'd7});
    chk("s5_coinc_data", data_a, vecs[7].exp_data);
    chk("s5_coinc_short", short_a, 1'b0);

    // Reset asserted in the middle of a captured frame.
    step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h1234, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    chk("s6_pre_we", we_a, 1'b1);
    reset = 1'b1;
    step(1'b1, 16'h9ABC, 1'b0);
    chk("s6_rst_we", we_a, 1'b0);
    chk("s6_rst_addr", addr_a, 5'd0);
    chk("s6_rst_fc", fc_a, 8'd0);
    chk("s6_rst_busy", busy_a, 1'b0);
    chk("s6_rst_rb", rb_a, 1'b0);
    reset = 1'b0;
    mode_a = 2'b00;
    step(1'b0, 16'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
